// File: rtl/dense_to_csr_encoder_pkg.sv
// Shared definitions for the dense-to-CSR front-end and the SpMM core:
// default geometry, CSR array types and the encoder state encoding.
package dense_to_csr_encoder_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_MAX_NNZ = 16;
  localparam int DEF_IDX_W   = 4;
  localparam int DEF_N_ROWS  = 4;
  localparam int DEF_N_COLS  = 4;
  // Row pointers must be able to hold MAX_NNZ itself, hence one bit wider than a column index.
  localparam int DEF_PTR_W   = DEF_IDX_W + 1;

  typedef logic [0:DEF_MAX_NNZ-1][DEF_DATA_W-1:0] nv_arr_t;
  typedef logic [0:DEF_MAX_NNZ-1][DEF_IDX_W-1:0]  ci_arr_t;
  typedef logic [0:DEF_N_ROWS][DEF_PTR_W-1:0]     rp_arr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } enc_state_e;

  // Width of a row index; never zero so a single-row matrix still gets a real signal.
  function automatic int row_idx_w(input int n_rows);
    return (n_rows > 1) ? $clog2(n_rows) : 1;
  endfunction

endpackage

// File: rtl/dense_to_csr_encoder_row_col_cnt.sv
// Row-major position counter for the dense input stream. Steps one column
// per accepted beat, wraps to the next row at the last column, and reports
// when the current position is the last column / last element of the matrix.
module dense_to_csr_encoder_row_col_cnt #(
  parameter int N_ROWS = 4,
  parameter int N_COLS = 4,
  parameter int ROW_W  = 2,
  parameter int COL_W  = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             step_i,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o,
  output logic             last_col_o,
  output logic             last_o
);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;

  // Position flags and next position.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    row_d      = row_q;
    col_d      = col_q;
    last_col_o = (col_q == COL_W'(N_COLS - 1));
    last_o     = last_col_o && (row_q == ROW_W'(N_ROWS - 1));
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (step_i) begin
      if (last_col_o) begin
        col_d = '0;
        row_d = last_o ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: state is updated with non-blocking (<=) so every flop samples pre-edge values, independent of statement order.
    if (!rst_ni) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o = row_q;
  assign col_o = col_q;

endmodule

// File: rtl/dense_to_csr_encoder.sv
// Streaming dense-to-CSR encoder. Consumes a row-major dense matrix one
// element per beat and builds the NV / CI / RP arrays in place; done_o
// marks the arrays complete and they hold until the next start_i.
module dense_to_csr_encoder
  import dense_to_csr_encoder_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MAX_NNZ = DEF_MAX_NNZ,
  parameter int IDX_W   = DEF_IDX_W,
  parameter int N_ROWS  = DEF_N_ROWS,
  parameter int N_COLS  = DEF_N_COLS,
  parameter int PTR_W   = IDX_W + 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            start_i,
  input  logic                            elem_valid_i,
  output logic                            elem_ready_o,
  input  logic [DATA_W-1:0]               elem_data_i,
  output logic [0:MAX_NNZ-1][DATA_W-1:0]  nv_o,
  output logic [0:MAX_NNZ-1][IDX_W-1:0]   ci_o,
  output logic [0:N_ROWS][PTR_W-1:0]      rp_o,
  output logic [PTR_W-1:0]                nnz_o,
  output logic                            overflow_o,
  output logic                            done_o
);

  localparam int ROW_W = row_idx_w(N_ROWS);

  enc_state_e state_q, state_d;

  logic [0:MAX_NNZ-1][DATA_W-1:0] nv_q, nv_d;
  logic [0:MAX_NNZ-1][IDX_W-1:0]  ci_q, ci_d;
  logic [0:N_ROWS][PTR_W-1:0]     rp_q, rp_d;
  logic [PTR_W-1:0]               nnz_q, nnz_d;
  logic                           overflow_q, overflow_d;

  logic             beat;
  logic [ROW_W-1:0] row;
  logic [IDX_W-1:0] col;
  logic             last_col;
  logic             last;

  // A restart outranks a beat presented in the same cycle.
  assign beat = (state_q == LOAD) && elem_valid_i && !start_i;

  dense_to_csr_encoder_row_col_cnt #(
    .N_ROWS (N_ROWS),
    .N_COLS (N_COLS),
    .ROW_W  (ROW_W),
    .COL_W  (IDX_W)
  ) u_row_col_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (start_i),
    .step_i     (beat),
    .row_o      (row),
    .col_o      (col),
    .last_col_o (last_col),
    .last_o     (last)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: start_i always (re)enters LOAD; the final beat closes the matrix.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = LOAD;
      LOAD:    if (start_i) state_d = LOAD;
               else if (beat && last) state_d = DONE;
      DONE:    if (start_i) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the registered state only.
  always_comb begin
    elem_ready_o = (state_q == LOAD);
    done_o       = (state_q == DONE);
  end

  // CSR array update: clear on start, append nonzeros, close a row pointer at each row end.
  always_comb begin
    nv_d       = nv_q;
    ci_d       = ci_q;
    rp_d       = rp_q;
    nnz_d      = nnz_q;
    overflow_d = overflow_q;
    if (start_i) begin
      nv_d       = '0;
      ci_d       = '0;
      rp_d       = '0;
      nnz_d      = '0;
      overflow_d = 1'b0;
    end else if (beat) begin
      if (elem_data_i != '0) begin
        if (nnz_q < PTR_W'(MAX_NNZ)) begin
          for (int i = 0; i < MAX_NNZ; i++) begin
            if (nnz_q == PTR_W'(i)) begin
              nv_d[i] = elem_data_i;
              ci_d[i] = col;
            end
          end
          nnz_d = nnz_q + PTR_W'(1);
        end else begin
          overflow_d = 1'b1;
        end
      end
      // rp[0] is never written, so it stays 0 from the last clear.
      if (last_col) begin
        for (int r = 0; r < N_ROWS; r++) begin
          if (row == ROW_W'(r)) rp_d[r+1] = nnz_d;
        end
      end
    end
  end

  // CSR array registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: the NV/CI/RP arrays are plain flops with reset, not RAM: they are visible outputs that must read 0 out of reset.
    if (!rst_ni) begin
      nv_q       <= '0;
      ci_q       <= '0;
      rp_q       <= '0;
      nnz_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      nv_q       <= nv_d;
      ci_q       <= ci_d;
      rp_q       <= rp_d;
      nnz_q      <= nnz_d;
      overflow_q <= overflow_d;
    end
  end

  assign nv_o       = nv_q;
  assign ci_o       = ci_q;
  assign rp_o       = rp_q;
  assign nnz_o      = nnz_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_dense_to_csr_encoder.sv
// Bench for dense_to_csr_encoder: two instances share one input stream, one
// with 16-entry capacity and one with 8, so overflow is exercised alongside
// the normal path. Expected CSR results are queued when a matrix is sent and
// popped when done_o is seen.
module tb_dense_to_csr_encoder;

  typedef logic [0:15][31:0] mat_t;

  typedef struct packed {
    logic [0:15][31:0] nv;
    logic [0:15][3:0]  ci;
    logic [0:4][4:0]   rp;
    logic [4:0]        nnz;
    logic              ovf;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic        elem_valid_i;
  logic [31:0] elem_data_i;

  logic             ready16, done16, ovf16;
  logic [0:15][31:0] nv16;
  logic [0:15][3:0]  ci16;
  logic [0:4][4:0]   rp16;
  logic [4:0]        nnz16;

  logic             ready8, done8, ovf8;
  logic [0:7][31:0] nv8;
  logic [0:7][3:0]  ci8;
  logic [0:4][4:0]  rp8;
  logic [4:0]       nnz8;

  int checks = 0;
  int errors = 0;

  exp_t q16[$];
  exp_t q8[$];

  dense_to_csr_encoder u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start_i),
    .elem_valid_i (elem_valid_i),
    .elem_ready_o (ready16),
    .elem_data_i  (elem_data_i),
    .nv_o         (nv16),
    .ci_o         (ci16),
    .rp_o         (rp16),
    .nnz_o        (nnz16),
    .overflow_o   (ovf16),
    .done_o       (done16)
  );

  dense_to_csr_encoder #(.MAX_NNZ(8)) u_dut8 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start_i),
    .elem_valid_i (elem_valid_i),
    .elem_ready_o (ready8),
    .elem_data_i  (elem_data_i),
    .nv_o         (nv8),
    .ci_o         (ci8),
    .rp_o         (rp8),
    .nnz_o        (nnz8),
    .overflow_o   (ovf8),
    .done_o       (done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference CSR built directly from the dense matrix for a given capacity.
  function automatic exp_t model(input mat_t m, input int cap);
    exp_t e;
    int   n;
    e = '0;
    n = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (m[r*4+c] != 32'd0) begin
          if (n < cap) begin
            e.nv[n] = m[r*4+c];
            e.ci[n] = 4'(c);
            n++;
          end else begin
            e.ovf = 1'b1;
          end
        end
        if (c == 3) e.rp[r+1] = 5'(n);
      end
    end
    e.nnz = 5'(n);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_result(input string tag);
    exp_t e16, e8;
    if (q16.size() == 0 || q8.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s/scoreboard: observed empty queue expected a pending result", tag);
      return;
    end
    e16 = q16.pop_front();
    e8  = q8.pop_front();
    check({tag, "/done"},  512'(done16), 512'(1'b1));
    check({tag, "/nv"},    512'(nv16),   512'(e16.nv));
    check({tag, "/ci"},    512'(ci16),   512'(e16.ci));
    check({tag, "/rp"},    512'(rp16),   512'(e16.rp));
    check({tag, "/nnz"},   512'(nnz16),  512'(e16.nnz));
    check({tag, "/ovf"},   512'(ovf16),  512'(e16.ovf));
    check({tag, "/done8"}, 512'(done8),  512'(1'b1));
    check({tag, "/nv8"},   512'(nv8),    512'(e8.nv[0:7]));
    check({tag, "/ci8"},   512'(ci8),    512'(e8.ci[0:7]));
    check({tag, "/rp8"},   512'(rp8),    512'(e8.rp));
    check({tag, "/nnz8"},  512'(nnz8),   512'(e8.nnz));
    check({tag, "/ovf8"},  512'(ovf8),   512'(e8.ovf));
  endtask

  // Sends a full matrix; optional random valid gaps; optional valid beat alongside start_i.
  task automatic run_matrix(input string tag, input mat_t m, input bit gaps,
                            input bit valid_with_start, input int exp_cycles);
    int cyc;
    q16.push_back(model(m, 16));
    q8.push_back(model(m, 8));
    start_i      = 1'b1;
    elem_valid_i = valid_with_start;
    elem_data_i  = 32'hDEAD_BEEF;
    tick();
    cyc          = 1;
    start_i      = 1'b0;
    elem_valid_i = 1'b0;
    check({tag, "/ready"},     512'(ready16), 512'(1'b1));
    check({tag, "/nnz_clear"}, 512'(nnz16),   512'(0));
    check({tag, "/done_clear"},512'(done16),  512'(1'b0));
    for (int k = 0; k < 16; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          tick();
          cyc++;
        end
      end
      elem_valid_i = 1'b1;
      elem_data_i  = m[k];
      tick();
      cyc++;
      elem_valid_i = 1'b0;
      if (k == 14) check({tag, "/done_early"}, 512'(done16), 512'(1'b0));
    end
    if (exp_cycles > 0) check({tag, "/latency"}, 512'(cyc), 512'(exp_cycles));
    compare_result(tag);
  endtask

  mat_t mat_a, mat_zero, mat_ones;

  initial begin
    mat_a = {32'd0, 32'd0, 32'd1, 32'd0,
             32'd0, 32'd5, 32'd7, 32'd0,
             32'd9, 32'd0, 32'd0, 32'd4,
             32'd2, 32'd6, 32'd0, 32'd0};
    mat_zero = '0;
    for (int i = 0; i < 16; i++) mat_ones[i] = 32'd1;

    rst_n        = 1'b0;
    start_i      = 1'b0;
    elem_valid_i = 1'b0;
    elem_data_i  = '0;
    repeat (2) tick();

    check("reset/ready", 512'(ready16), 512'(1'b0));
    check("reset/done",  512'(done16),  512'(1'b0));
    check("reset/nv",    512'(nv16),    512'(0));
    check("reset/ci",    512'(ci16),    512'(0));
    check("reset/rp",    512'(rp16),    512'(0));
    check("reset/nnz",   512'(nnz16),   512'(0));
    check("reset/ovf",   512'(ovf16),   512'(1'b0));

    @(negedge clk);
    rst_n = 1'b1;
    // Valid while IDLE must be ignored.
    elem_valid_i = 1'b1;
    elem_data_i  = 32'd3;
    repeat (2) tick();
    elem_valid_i = 1'b0;
    check("idle/ready", 512'(ready16), 512'(1'b0));
    check("idle/nnz",   512'(nnz16),   512'(0));

    // Scenario 1: matrix A, valid every cycle, done 17 cycles after start_i.
    run_matrix("s1", mat_a, 1'b0, 1'b0, 17);
    check("s1/rp_lit",  512'(rp16),  512'({5'd0, 5'd1, 5'd3, 5'd5, 5'd7}));
    check("s1/nnz_lit", 512'(nnz16), 512'(7));

    // Scenario 2: same matrix with random valid gaps.
    run_matrix("s2", mat_a, 1'b1, 1'b0, 0);

    // Outputs hold while done, even with valid beats offered.
    q16.push_back(model(mat_a, 16));
    q8.push_back(model(mat_a, 8));
    elem_valid_i = 1'b1;
    elem_data_i  = 32'd11;
    repeat (3) tick();
    elem_valid_i = 1'b0;
    compare_result("hold");

    // Scenario 3: all zeros.
    run_matrix("s3", mat_zero, 1'b0, 1'b0, 0);

    // Scenario 4: all ones; 16-entry instance fills exactly, 8-entry instance overflows.
    run_matrix("s4", mat_ones, 1'b0, 1'b0, 0);
    check("s4/rp8_lit",  512'(rp8),  512'({5'd0, 5'd4, 5'd8, 5'd8, 5'd8}));
    check("s4/ovf8_lit", 512'(ovf8), 512'(1'b1));
    check("s4/rp_lit",   512'(rp16), 512'({5'd0, 5'd4, 5'd8, 5'd12, 5'd16}));

    // Scenario 5a: restart after 6 beats; restart carries a valid beat that must not be consumed.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      elem_valid_i = 1'b1;
      elem_data_i  = mat_a[k];
      tick();
    end
    elem_valid_i = 1'b0;
    check("s5/partial_nnz", 512'(nnz16), 512'(2));
    check("s5/partial_rp1", 512'(rp16[1]), 512'(1));
    run_matrix("s5", mat_a, 1'b0, 1'b1, 17);

    // Scenario 5b: asynchronous reset in the middle of LOAD.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      elem_valid_i = 1'b1;
      elem_data_i  = mat_ones[k];
      tick();
    end
    elem_valid_i = 1'b0;
    check("rst_mid/nnz_before", 512'(nnz16), 512'(5));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid/ready", 512'(ready16), 512'(1'b0));
    check("rst_mid/nnz",   512'(nnz16),   512'(0));
    check("rst_mid/nv",    512'(nv16),    512'(0));
    check("rst_mid/rp",    512'(rp16),    512'(0));
    check("rst_mid/ci",    512'(ci16),    512'(0));
    @(negedge clk);
    rst_n        = 1'b1;
    elem_valid_i = 1'b1;
    elem_data_i  = 32'd3;
    repeat (3) tick();
    elem_valid_i = 1'b0;
    check("rst_mid/ready_after", 512'(ready16), 512'(1'b0));
    check("rst_mid/nnz_after",   512'(nnz16),   512'(0));
    check("rst_mid/done_after",  512'(done16),  512'(1'b0));

    // Encoder recovers normally after the reset.
    run_matrix("post_rst", mat_a, 1'b0, 1'b0, 17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
